// File: rtl/spi_word_receiver.sv
// spi_word_receiver: mode-0 SPI slave receiver assembling MSB-first words with valid/ack handshake
module spi_word_receiver #(
  parameter int WORD_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs_n,
  input  logic                  word_ack,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  output logic                  overrun,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int CW = $clog2(WORD_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_q, mosi_q, cs_q;
  logic                    sck_s, mosi_s, cs_s, sck_d, rise, bit_q;
  logic [WORD_WIDTH-1:0]   shift;
  logic [CW-1:0]           cnt;
  logic                    done, cs_err, hold_err;
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign done     = state == SHIFT && !cs_s && rise && cnt == CW'(WORD_WIDTH - 1);
  assign cs_err   = state == SHIFT && cs_s && cnt != '0;
  assign hold_err = state == HOLD && rise;
  // rise and bit_q are registered together so the sampled bit stays aligned to its edge
  always_ff @(posedge clk) begin
    if (res) begin
      sck_q       <= '0;
      mosi_q      <= '0;
      cs_q        <= '1;
      sck_d       <= 1'b0;
      rise        <= 1'b0;
      bit_q       <= 1'b0;
      shift       <= '0;
      cnt         <= '0;
      state       <= IDLE;
      word_out    <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sck_q       <= {sck_q[SYNC_STAGES-2:0], sck};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sck_d       <= sck_s;
      rise        <= sck_s & ~sck_d;
      bit_q       <= mosi_s;
      word_valid  <= done | (word_valid & ~word_ack);
      overrun     <= ~word_ack & (overrun | (done & word_valid));
      frame_error <= cs_err | hold_err | (frame_error & ~word_ack);
      busy        <= ~cs_s;
      if (done) word_out <= {shift[WORD_WIDTH-2:0], bit_q};
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!cs_s) state <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (rise) begin
            shift <= {shift[WORD_WIDTH-2:0], bit_q};
            cnt   <= done ? '0 : cnt + 1'b1;
            state <= done ? HOLD : SHIFT;
          end
        end
        HOLD: if (cs_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver: directed and randomized frames checked against a frame-level model
module tb_spi_word_receiver;
  localparam int W = 16, S = 2;
  logic clk = 0, res = 1, sck = 0, mosi = 0, cs_n = 1, word_ack = 0;
  logic [W-1:0] word_out;
  logic word_valid, overrun, frame_error, busy;
  int n_cmp = 0, n_bad = 0, cyc = 0, rise_cyc = 0, valid_cyc = -1;
  logic wv_prev = 0;
  logic [W-1:0] m_w;
  bit m_v, m_ov, m_fe;

  spi_word_receiver #(.WORD_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .res(res), .sck(sck), .mosi(mosi), .cs_n(cs_n), .word_ack(word_ack),
    .word_out(word_out), .word_valid(word_valid), .overrun(overrun),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (word_valid && !wv_prev) valid_cyc = cyc;
    wv_prev = word_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_w = '0; m_v = 0; m_ov = 0; m_fe = 0;
  endtask

  // one chip-select window with n rises carrying d MSB-first; a = ack lands on completion
  task automatic model_window(input logic [31:0] d, input int n, input bit a);
    if (n >= W) begin
      m_ov = a ? 0 : (m_ov | m_v);
      m_fe = a ? 0 : m_fe;
      m_v  = 1;
      m_w  = d[31:16];
      if (n > W) m_fe = 1;
    end else if (n > 0) m_fe = 1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".word"}, 32'(word_out), 32'(m_w));
    check({tag, ".valid"}, 32'(word_valid), 32'(m_v));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ov));
    check({tag, ".ferr"}, 32'(frame_error), 32'(m_fe));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_ack();
    word_ack = 1;
    tick(1);
    word_ack = 0;
    m_v = 0; m_ov = 0; m_fe = 0;
    check("ack.valid", 32'(word_valid), 32'd0);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n, input bit a);
    for (int i = 0; i < n; i++) begin
      mosi = d[31-i];
      tick(1);
      sck = 1;
      rise_cyc = cyc;
      tick(2);
      sck = 0;
      tick(1);
      if (a && i == n - 1) begin
        word_ack = 1;
        tick(1);
        word_ack = 0;
      end
    end
  endtask

  task automatic close_cs();
    tick(2);
    cs_n = 1;
    tick(6);
  endtask

  task automatic window(input string tag, input logic [31:0] d, input int n, input bit a);
    cs_n = 0;
    tick(4);
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    send_bits(d, n, a);
    close_cs();
    model_window(d, n, a);
    check_model(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int r, n;
    bit a;
    model_reset();
    tick(3);
    check_model("reset");
    res = 0;
    tick(2);
    window("single", 32'hA5C3_0000, 16, 0);
    check("latency", 32'(valid_cyc - rise_cyc), 32'(S + 2));
    do_ack();
    window("short", 32'hFFFF_0000, 7, 0);
    do_ack();
    window("ovr1", 32'h1234_0000, 16, 0);
    window("ovr2", 32'hBEEF_0000, 16, 0);
    do_ack();
    check("ovr.clr", 32'(overrun), 32'd0);
    window("extra", 32'h8001_8000, 17, 0);
    do_ack();
    d = 32'h9A3C_0000;
    cs_n = 0;
    tick(4);
    send_bits(d, 9, 0);
    res = 1;
    tick(2);
    model_reset();
    check_model("midrst");
    res = 0;
    send_bits(d << 9, 7, 0);
    close_cs();
    model_window(d << 9, 7, 0);
    check_model("after_rst");
    do_ack();
    window("clean", 32'h0F0F_0000, 16, 0);
    do_ack();
    window("coin1", 32'h7E81_0000, 16, 0);
    window("coin2", 32'h5555_0000, 16, 1);
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) do_ack();
      r = $urandom_range(0, 9);
      n = r < 6 ? 16 : r < 8 ? $urandom_range(1, 15) : r == 8 ? 17 : 0;
      a = n == 16 && $urandom_range(0, 3) == 0;
      window("rand", $urandom, n, a);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
